// File: rtl/pc_pkg.sv
// Shared types and default widths for the program-counter / jump-table unit.
package pc_pkg;

  localparam int PC_W          = 12;
  localparam int N_ENTRIES_DEF = 16;
  localparam int RS_DEPTH_DEF  = 4;

  // One jump-table entry; off is a PC-relative offset unless abs is set.
  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] src;
    logic [PC_W-1:0] off;
    logic            abs;
  } jt_entry_t;

  typedef enum logic [1:0] {
    SEL_HOLD,
    SEL_INC,
    SEL_TGT,
    SEL_POP
  } pc_sel_t;

endpackage

// File: rtl/pc_jump_unit_if.sv
// Control/table/status bundle between the decode-control block and pc_jump_unit.
interface pc_jump_unit_if
  import pc_pkg::*;
#(
  parameter int D     = PC_W,
  parameter int IDX_W = 4
);

  // Handshake: there is no valid/ready pair. Every input is level-sampled on
  // each rising clk edge and consumed in that cycle unless stall or done
  // suppresses it; table writes are accepted on every edge with tbl_we high.
  logic             stall;
  logic             jump;
  logic             call;
  logic             ret;
  logic             tbl_we;
  logic [IDX_W-1:0] tbl_idx;
  logic [D-1:0]     tbl_src;
  logic [D-1:0]     tbl_off;
  logic             tbl_abs;

  logic [D-1:0]     pc;
  logic             hit;
  logic             done;
  logic             miss_err;
  logic             rs_err;
  pc_sel_t          sel;

  modport master (
    output stall, jump, call, ret,
    output tbl_we, tbl_idx, tbl_src, tbl_off, tbl_abs,
    input  pc, hit, done, miss_err, rs_err, sel
  );

  modport slave (
    input  stall, jump, call, ret,
    input  tbl_we, tbl_idx, tbl_src, tbl_off, tbl_abs,
    output pc, hit, done, miss_err, rs_err, sel
  );

endinterface

// File: rtl/return_stack.sv
// LIFO of return addresses with a registered fill pointer; push and pop are
// never requested together by the owning unit.
module return_stack #(
  parameter int RS_DEPTH = 4,
  parameter int D        = 12
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [D-1:0] push_data,
  output logic [D-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(RS_DEPTH + 1);
  localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

  logic [D-1:0]     mem [RS_DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_m1;

  assign ptr_m1 = ptr - PTR_W'(1);
  assign full   = (ptr == PTR_W'(RS_DEPTH));
  assign empty  = (ptr == '0);
  assign top    = mem[ptr_m1[IDX_W-1:0]];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (push && !full) begin
      ptr <= ptr + PTR_W'(1);
    end else if (pop && !empty) begin
      ptr <= ptr_m1;
    end
  end

  // Storage is not reset; a push in a reset cycle is simply not committed.
  always_ff @(posedge clk) begin
    if (reset_n && push && !full) begin
      mem[ptr[IDX_W-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/pc_jump_unit.sv
// Registered PC with a run-time jump table, call/return stack, stall and
// sticky program-end / error flags.
module pc_jump_unit
  import pc_pkg::*;
#(
  parameter int           D         = PC_W,
  parameter int           N_ENTRIES = N_ENTRIES_DEF,
  parameter int           RS_DEPTH  = RS_DEPTH_DEF,
  parameter logic [D-1:0] LAST_ADDR = 12'hFFF
) (
  input  logic           clk,
  input  logic           reset_n,
  pc_jump_unit_if.slave  bus
);

  // Table entries use the pc_pkg width, so D is expected to equal PC_W.
  jt_entry_t    jt_q [N_ENTRIES];

  logic [D-1:0] pc_q;
  logic [D-1:0] pc_d;
  logic [D-1:0] pc_inc;
  logic [D-1:0] tgt;
  logic         done_q;
  logic         miss_q;
  logic         rs_q;

  logic         hit_c;
  logic [D-1:0] m_off;
  logic         m_abs;

  pc_sel_t      sel;
  logic         push;
  logic         pop;
  logic         miss_set;
  logic         rs_set;
  logic         done_set;

  logic [D-1:0] rs_top;
  logic         rs_full;
  logic         rs_empty;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        jt_q[i].valid <= 1'b0;
      end
    end else if (bus.tbl_we) begin
      jt_q[bus.tbl_idx] <= '{valid: 1'b1, src: bus.tbl_src,
                             off: bus.tbl_off, abs: bus.tbl_abs};
    end
  end

  // Scan from the top down so the lowest matching index is the one kept.
  always_comb begin
    hit_c = 1'b0;
    m_off = '0;
    m_abs = 1'b0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (jt_q[i].valid && (jt_q[i].src == pc_q)) begin
        hit_c = 1'b1;
        m_off = jt_q[i].off;
        m_abs = jt_q[i].abs;
      end
    end
  end

  assign pc_inc = pc_q + D'(1);
  assign tgt    = m_abs ? m_off : (pc_q + m_off);

  always_comb begin
    sel      = SEL_INC;
    push     = 1'b0;
    pop      = 1'b0;
    miss_set = 1'b0;
    rs_set   = 1'b0;
    done_set = 1'b0;
    if (done_q || bus.stall) begin
      sel = SEL_HOLD;
    end else if (pc_q == LAST_ADDR) begin
      sel      = SEL_HOLD;
      done_set = 1'b1;
    end else if (bus.ret) begin
      if (rs_empty) begin
        rs_set = 1'b1;
      end else begin
        sel = SEL_POP;
        pop = 1'b1;
      end
    end else if (bus.call) begin
      if (hit_c) begin
        sel = SEL_TGT;
        if (rs_full) rs_set = 1'b1;
        else         push   = 1'b1;
      end else begin
        miss_set = 1'b1;
      end
    end else if (bus.jump) begin
      if (hit_c) sel      = SEL_TGT;
      else       miss_set = 1'b1;
    end
  end

  always_comb begin
    pc_d = pc_q;
    case (sel)
      SEL_HOLD: pc_d = pc_q;
      SEL_INC:  pc_d = pc_inc;
      SEL_TGT:  pc_d = tgt;
      SEL_POP:  pc_d = rs_top;
      default:  pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q   <= '0;
      done_q <= 1'b0;
      miss_q <= 1'b0;
      rs_q   <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      done_q <= done_q | done_set;
      miss_q <= miss_q | miss_set;
      rs_q   <= rs_q | rs_set;
    end
  end

  return_stack #(
    .RS_DEPTH (RS_DEPTH),
    .D        (D)
  ) u_rs (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (rs_top),
    .full      (rs_full),
    .empty     (rs_empty)
  );

  assign bus.pc       = pc_q;
  assign bus.hit      = hit_c;
  assign bus.done     = done_q;
  assign bus.miss_err = miss_q;
  assign bus.rs_err   = rs_q;
  assign bus.sel      = sel;

endmodule
